crack_scheduler: RTL and testbench

//  Splits a first-character index range across N_ENGINES password_cracker

---
 rtl/crack_scheduler_pkg.sv | 20 ++
 rtl/crack_slice_gen.sv | 64 ++++++
 rtl/crack_scheduler.sv | 152 +++++++++++++++
 tb/tb_crack_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_scheduler_pkg.sv
// Shared constants and state encoding for the crack scheduler and the password_cracker engines.
// The range check lives here so every block agrees on what a legal charset range is.
package crack_scheduler_pkg;

    localparam int IDX_W   = 6;
    localparam int CHARSET = 36;
    localparam int PW_BITS = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    function automatic logic range_legal(input logic [IDX_W-1:0] lo, input logic [IDX_W-1:0] hi);
        return (hi >= lo) && ({1'b0, hi} < (IDX_W+1)'(CHARSET));
    endfunction

endpackage

// File: rtl/crack_slice_gen.sv
// Sequential slice calculator: latches the range, then emits one engine's [from,to] per step,
// marking engines whose start lies past hi as unused (their from/to stay 0).
module crack_slice_gen
    import crack_scheduler_pkg::*;
#(
    parameter int N_ENGINES = 4,
    parameter int LOG2_N    = 2,
    parameter int IW        = (LOG2_N < 1) ? 1 : LOG2_N
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init,
    input  logic                       step,
    input  logic [IW-1:0]              idx,
    input  logic [IDX_W-1:0]           range_lo,
    input  logic [IDX_W-1:0]           range_hi,
    output logic [N_ENGINES*IDX_W-1:0] eng_from,
    output logic [N_ENGINES*IDX_W-1:0] eng_to,
    output logic [N_ENGINES-1:0]       unused_mask
);

    // Wide enough that base can run past hi by up to N slices without wrapping.
    localparam int BW = IDX_W + LOG2_N + 1;

    logic [IDX_W-1:0] lo_q;
    logic [IDX_W-1:0] hi_q;
    logic [BW-1:0]    base;
    logic [BW-1:0]    hi_ext;
    logic [BW-1:0]    total_w;
    logic [BW-1:0]    slice_w;
    logic [BW-1:0]    last;

    assign hi_ext  = BW'(hi_q);
    assign total_w = BW'(hi_q) - BW'(lo_q) + BW'(1);
    assign slice_w = (total_w + BW'(N_ENGINES - 1)) >> LOG2_N;
    assign last    = base + slice_w - BW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q        <= '0;
            hi_q        <= '0;
            base        <= '0;
            eng_from    <= '0;
            eng_to      <= '0;
            unused_mask <= '0;
        end else if (init) begin
            lo_q        <= range_lo;
            hi_q        <= range_hi;
            base        <= BW'(range_lo);
            eng_from    <= '0;
            eng_to      <= '0;
            unused_mask <= '0;
        end else if (step) begin
            if (base > hi_ext) begin
                unused_mask[idx] <= 1'b1;
            end else begin
                eng_from[idx*IDX_W +: IDX_W] <= base[IDX_W-1:0];
                eng_to[idx*IDX_W +: IDX_W]   <= (last > hi_ext) ? hi_q : last[IDX_W-1:0];
            end
            base <= base + slice_w;
        end
    end

endmodule

// File: rtl/crack_scheduler.sv
// Splits a charset index range over N cracker engines, launches them and folds their
// results into one found/done outcome; the first hit or a host abort stops every engine.
module crack_scheduler
    import crack_scheduler_pkg::*;
#(
    parameter int N_ENGINES = 4,
    parameter int LOG2_N    = 2,
    parameter int FE_W      = (LOG2_N < 1) ? 1 : LOG2_N
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [PW_BITS-1:0]         password_in,
    input  logic [IDX_W-1:0]           range_lo,
    input  logic [IDX_W-1:0]           range_hi,
    output logic                       busy,
    output logic                       found,
    output logic                       done,
    output logic                       err,
    output logic [FE_W-1:0]            found_engine,
    output logic [PW_BITS-1:0]         eng_password,
    output logic [N_ENGINES*IDX_W-1:0] eng_from,
    output logic [N_ENGINES*IDX_W-1:0] eng_to,
    output logic [N_ENGINES-1:0]       eng_start,
    output logic [N_ENGINES-1:0]       eng_abort,
    input  logic [N_ENGINES-1:0]       eng_found,
    input  logic [N_ENGINES-1:0]       eng_done,
    output state_t                     state_dbg
);

    // start and abort are single-cycle requests with no back-pressure: start counts only
    // when sampled in IDLE, abort only outside IDLE; anything else is silently dropped.
    state_t                 state;
    logic [FE_W-1:0]        setup_idx;
    logic [N_ENGINES-1:0]   live;
    logic [N_ENGINES-1:0]   live_next;
    logic [N_ENGINES-1:0]   hit;
    logic [N_ENGINES-1:0]   unused_mask;
    logic [FE_W-1:0]        hit_idx;
    logic                   legal;
    logic                   accept;

    assign legal     = range_legal(range_lo, range_hi);
    assign accept    = (state == ST_IDLE) && start && legal;
    assign state_dbg = state;

    crack_slice_gen #(
        .N_ENGINES (N_ENGINES),
        .LOG2_N    (LOG2_N),
        .IW        (FE_W)
    ) u_slice_gen (
        .clk         (clk),
        .rst         (rst),
        .init        (accept),
        .step        ((state == ST_SETUP) && !abort),
        .idx         (setup_idx),
        .range_lo    (range_lo),
        .range_hi    (range_hi),
        .eng_from    (eng_from),
        .eng_to      (eng_to),
        .unused_mask (unused_mask)
    );

    // Only engines that were launched and have not yet reported done can raise a hit.
    always_comb begin
        hit       = eng_found & live;
        live_next = live & ~eng_done;
        hit_idx   = '0;
        for (int i = N_ENGINES - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx = FE_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            setup_idx    <= '0;
            live         <= '0;
            busy         <= 1'b0;
            found        <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            found_engine <= '0;
            eng_password <= '0;
            eng_start    <= '0;
            eng_abort    <= '0;
        end else begin
            eng_start <= '0;
            eng_abort <= '0;
            if (abort && (state != ST_IDLE)) begin
                eng_abort <= '1;
                done      <= 1'b1;
                found     <= 1'b0;
                err       <= 1'b0;
                busy      <= 1'b0;
                live      <= '0;
                state     <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            found        <= 1'b0;
                            found_engine <= '0;
                            if (legal) begin
                                eng_password <= password_in;
                                done         <= 1'b0;
                                err          <= 1'b0;
                                busy         <= 1'b1;
                                setup_idx    <= '0;
                                state        <= ST_SETUP;
                            end else begin
                                done <= 1'b1;
                                err  <= 1'b1;
                                busy <= 1'b0;
                            end
                        end
                    end
                    ST_SETUP: begin
                        if (setup_idx == FE_W'(N_ENGINES - 1)) state <= ST_LAUNCH;
                        setup_idx <= setup_idx + FE_W'(1);
                    end
                    ST_LAUNCH: begin
                        eng_start <= ~unused_mask;
                        live      <= ~unused_mask;
                        state     <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (|hit) begin
                            found        <= 1'b1;
                            found_engine <= hit_idx;
                            eng_abort    <= '1;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            live         <= '0;
                            state        <= ST_IDLE;
                        end else begin
                            live <= live_next;
                            if (live_next == '0) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench for crack_scheduler: a cycle-count based reference model checked every
// cycle, plus literal slice/launch/result expectations for the canonical scenarios.
module tb_crack_scheduler;
    import crack_scheduler_pkg::*;

    localparam int N = 4;
    localparam int W = IDX_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [PW_BITS-1:0] password_in = '0;
    logic [W-1:0]       range_lo = '0;
    logic [W-1:0]       range_hi = '0;
    logic [N-1:0]       eng_found = '0;
    logic [N-1:0]       eng_done = '0;
    logic               busy, found, done, err;
    logic [1:0]         found_engine;
    logic [PW_BITS-1:0] eng_password;
    logic [N*W-1:0]     eng_from, eng_to;
    logic [N-1:0]       eng_start, eng_abort;
    state_t             state_dbg;

    crack_scheduler #(.N_ENGINES(N), .LOG2_N(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .password_in  (password_in),
        .range_lo     (range_lo),
        .range_hi     (range_hi),
        .busy         (busy),
        .found        (found),
        .done         (done),
        .err          (err),
        .found_engine (found_engine),
        .eng_password (eng_password),
        .eng_from     (eng_from),
        .eng_to       (eng_to),
        .eng_start    (eng_start),
        .eng_abort    (eng_abort),
        .eng_found    (eng_found),
        .eng_done     (eng_done),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic               e_busy = 0, e_found = 0, e_done = 0, e_err = 0;
    logic [1:0]         e_fe = '0;
    logic [PW_BITS-1:0] e_pw = '0;
    logic [N*W-1:0]     e_from = '0, e_to = '0;
    logic [N-1:0]       e_start = '0, e_abort = '0;
    bit                 m_active = 0;
    int                 m_cyc = 0, m_lo = 0, m_hi = 0;
    logic [N-1:0]       m_live = '0, m_used = '0, m_hit;
    bit                 m_u;
    int                 m_f, m_t;

    // Slice i of [lo,hi] when the range is cut into N pieces of ceil(total/N).
    function automatic void slice_of(input int lo, input int hi, input int i,
                                     output bit used, output int f, output int t);
        int total, sl;
        total = hi - lo + 1;
        sl    = (total + N - 1) / N;
        f     = lo + i * sl;
        if (f > hi) begin
            used = 0; f = 0; t = 0;
        end else begin
            used = 1;
            t = f + sl - 1;
            if (t > hi) t = hi;
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_busy = 0; e_found = 0; e_done = 0; e_err = 0; e_fe = '0; e_pw = '0;
            e_from = '0; e_to = '0; e_start = '0; e_abort = '0;
            m_active = 0; m_live = '0;
        end else begin
            e_start = '0;
            e_abort = '0;
            if (!m_active) begin
                if (start) begin
                    e_found = 0;
                    e_fe    = '0;
                    if (int'(range_hi) < int'(range_lo) || int'(range_hi) >= CHARSET) begin
                        e_done = 1; e_err = 1; e_busy = 0;
                    end else begin
                        m_active = 1; m_cyc = 0;
                        m_lo = int'(range_lo); m_hi = int'(range_hi);
                        e_busy = 1; e_done = 0; e_err = 0; e_pw = password_in;
                        e_from = '0; e_to = '0;
                    end
                end
            end else begin
                m_cyc++;
                if (abort) begin
                    e_abort = '1; e_done = 1; e_found = 0; e_err = 0; e_busy = 0; m_active = 0;
                end else if (m_cyc <= N) begin
                    slice_of(m_lo, m_hi, m_cyc - 1, m_u, m_f, m_t);
                    e_from[(m_cyc-1)*W +: W] = W'(m_f);
                    e_to[(m_cyc-1)*W +: W]   = W'(m_t);
                end else if (m_cyc == N + 1) begin
                    for (int i = 0; i < N; i++) begin
                        slice_of(m_lo, m_hi, i, m_u, m_f, m_t);
                        m_used[i] = m_u;
                    end
                    e_start = m_used;
                    m_live  = m_used;
                end else begin
                    m_hit = eng_found & m_live;
                    if (m_hit != '0) begin
                        for (int i = N - 1; i >= 0; i--) if (m_hit[i]) e_fe = 2'(i);
                        e_found = 1; e_abort = '1; e_done = 1; e_busy = 0; m_active = 0;
                    end else begin
                        m_live = m_live & ~eng_done;
                        if (m_live == '0) begin
                            e_done = 1; e_busy = 0; m_active = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(e_busy));
            check("found", 64'(found), 64'(e_found));
            check("done", 64'(done), 64'(e_done));
            check("err", 64'(err), 64'(e_err));
            check("found_engine", 64'(found_engine), 64'(e_fe));
            check("eng_password", 64'(eng_password), 64'(e_pw));
            check("eng_from", 64'(eng_from), 64'(e_from));
            check("eng_to", 64'(eng_to), 64'(e_to));
            check("eng_start", 64'(eng_start), 64'(e_start));
            check("eng_abort", 64'(eng_abort), 64'(e_abort));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input int lo, input int hi, input logic [PW_BITS-1:0] pw);
        range_lo = W'(lo); range_hi = W'(hi); password_in = pw; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cycles(2);
        chk_en = 1'b1;
        check("reset_outputs", 64'({busy, found, done, err, eng_start, eng_abort}), 64'd0);
        check("reset_from_to", 64'({eng_from, eng_to}), 64'd0);
        rst = 1'b1;
        cycles(1);

        // 1: full range, four equal slices, launch five cycles after start
        do_start(0, 35, 32'h6162_6364);
        cycles(5);
        check("t1_eng_start", 64'(eng_start), 64'(4'b1111));
        check("t1_from", 64'(eng_from), 64'({6'd27, 6'd18, 6'd9, 6'd0}));
        check("t1_to", 64'(eng_to), 64'({6'd35, 6'd26, 6'd17, 6'd8}));
        eng_done = 4'b0011; cycles(1);
        eng_done = 4'b1100; cycles(1);
        eng_done = '0;
        check("t1_result", 64'({busy, found, done}), 64'(3'b001));
        cycles(2);

        // 2: 0..5 leaves engine 3 unused
        do_start(0, 5, 32'h3132_3334);
        cycles(5);
        check("t2_eng_start", 64'(eng_start), 64'(4'b0111));
        check("t2_from", 64'(eng_from), 64'({6'd0, 6'd4, 6'd2, 6'd0}));
        check("t2_to", 64'(eng_to), 64'({6'd0, 6'd5, 6'd3, 6'd1}));
        eng_done = 4'b1000; cycles(1);
        check("t2_unused_done_ignored", 64'(busy), 64'd1);
        eng_done = 4'b0111; cycles(1);
        eng_done = '0;
        check("t2_result", 64'({busy, found, done}), 64'(3'b001));
        cycles(2);

        // 3: single-index range, engine 0 hits
        do_start(10, 10, 32'h7a7a_7a7a);
        cycles(5);
        check("t3_eng_start", 64'(eng_start), 64'(4'b0001));
        check("t3_from", 64'(eng_from), 64'({6'd0, 6'd0, 6'd0, 6'd10}));
        check("t3_to", 64'(eng_to), 64'({6'd0, 6'd0, 6'd0, 6'd10}));
        eng_found = 4'b1000; cycles(1);
        eng_found = '0;
        check("t3_unused_found_ignored", 64'({busy, found}), 64'(2'b10));
        eng_found = 4'b0001; cycles(1);
        eng_found = '0;
        check("t3_found", 64'({busy, found, done, found_engine}), 64'(5'b011_00));
        check("t3_eng_abort", 64'(eng_abort), 64'(4'b1111));
        cycles(1);
        check("t3_eng_abort_pulse", 64'(eng_abort), 64'd0);
        cycles(1);

        // 4: start while busy is ignored; two engines hit together, lowest wins
        do_start(0, 35, 32'hdead_beef);
        cycles(2);
        do_start(3, 4, 32'h0000_0001);
        cycles(2);
        check("t4_ignored_start_from", 64'(eng_from), 64'({6'd27, 6'd18, 6'd9, 6'd0}));
        check("t4_password", 64'(eng_password), 64'h0000_0000_dead_beef);
        eng_found = 4'b1010; cycles(1);
        eng_found = '0;
        check("t4_found_engine", 64'({found, found_engine}), 64'(3'b1_01));
        cycles(2);

        // 5: illegal ranges; abort in IDLE does nothing
        do_start(20, 5, 32'h1111_1111);
        check("t5_inverted", 64'({busy, done, err}), 64'(3'b011));
        cycles(1);
        abort = 1'b1; cycles(1);
        abort = 1'b0;
        check("t5_idle_abort", 64'({busy, done, err, eng_abort}), 64'(7'b011_0000));
        do_start(0, 36, 32'h2222_2222);
        check("t5_hi_36", 64'({busy, done, err}), 64'(3'b011));
        cycles(6);
        check("t5_no_launch", 64'(eng_start), 64'd0);

        // 6: abort beats a same-cycle hit; async reset mid-run
        do_start(0, 35, 32'h4142_4344);
        check("t6_err_cleared", 64'({busy, err}), 64'(2'b10));
        cycles(6);
        abort = 1'b1; eng_found = 4'b0001; cycles(1);
        abort = 1'b0; eng_found = '0;
        check("t6_abort", 64'({busy, found, done, err, eng_abort}), 64'(8'b0010_1111));
        cycles(1);
        do_start(0, 35, 32'h5555_aaaa);
        cycles(7);
        #2 rst = 1'b0;
        #1;
        check("t6_async_flags", 64'({busy, found, done, err, found_engine}), 64'd0);
        check("t6_async_vectors", 64'({eng_start, eng_abort, eng_from, eng_to}), 64'd0);
        check("t6_async_password", 64'(eng_password), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cycles(1);
        do_start(0, 5, 32'h7777_8888);
        cycles(5);
        check("t6_after_reset_start", 64'(eng_start), 64'(4'b0111));
        eng_done = 4'b0111; cycles(1);
        eng_done = '0;
        check("t6_after_reset_done", 64'({busy, found, done}), 64'(3'b001));
        cycles(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
